// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end: button indices and default timing.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    START = 3'd0,
    STOP  = 3'd1,
    RESET = 3'd2,
    MIN   = 3'd3,
    SEC   = 3'd4,
    DIR   = 3'd5
  } btn_idx_e;

  localparam int unsigned NUM_BTN = 6;
  // Every input except the direction switch produces command pulses.
  localparam int unsigned NUM_CMD = NUM_BTN - 1;

  localparam int unsigned DEBOUNCE_MS_DEF = 20;
  localparam int unsigned HOLD_MS_DEF     = 500;
  localparam int unsigned REPEAT_MS_DEF   = 100;

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchronizer, tick-paced debounce counter,
// debounced level and its rising-edge strobe.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // A disagreement only accumulates on ticks; agreement discards the count.
    if (sync2_q != stable_q) begin
      cnt_d = cnt_q;
      if (tick) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~prev_q;

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch button front end: debounced inputs, prioritised single-cycle
// command pulses and auto-repeat for the minute/second increment buttons.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int unsigned HOLD_MS     = HOLD_MS_DEF,
  parameter int unsigned REPEAT_MS   = REPEAT_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1k,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_reset,
  input  logic btn_min,
  input  logic btn_sec,
  input  logic sw_dir,
  output logic start_p,
  output logic stop_p,
  output logic reset_p,
  output logic inc_min_p,
  output logic inc_sec_p,
  output logic dir
);

  localparam int unsigned HW = $clog2(HOLD_MS + 1);
  localparam logic [HW-1:0] HOLD_TOP    = HW'(HOLD_MS);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_MS - REPEAT_MS);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] stable_vec;
  logic [NUM_CMD-1:0] rise_vec;
  logic               dir_rise_unused;

  assign raw_vec = {sw_dir, btn_sec, btn_min, btn_reset, btn_stop, btn_start};

  genvar g;
  for (g = 0; g < NUM_CMD; g++) begin : g_cmd
    debounce_cell #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick_1k),
      .raw    (raw_vec[g]),
      .stable (stable_vec[g]),
      .rise   (rise_vec[g])
    );
  end

  debounce_cell #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_dir (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick_1k),
    .raw    (raw_vec[DIR]),
    .stable (stable_vec[DIR]),
    .rise   (dir_rise_unused)
  );

  // Auto-repeat channels: index 0 = minute button, 1 = second button.
  logic [1:0]    hold_stable;
  logic [1:0]    hold_rise;
  logic [1:0]    rep;
  logic [HW-1:0] hold_q [2];
  logic [HW-1:0] hold_d [2];

  assign hold_stable = {stable_vec[SEC], stable_vec[MIN]};
  assign hold_rise   = {rise_vec[SEC], rise_vec[MIN]};

  always_comb begin
    rep = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      hold_d[c] = hold_q[c];
      rep[c]    = hold_stable[c] && (hold_q[c] == HOLD_TOP);
      if (!hold_stable[c] || hold_rise[c]) begin
        hold_d[c] = '0;
      end else if (rep[c]) begin
        hold_d[c] = HOLD_RELOAD;
      end else if (tick_1k && (hold_q[c] != HOLD_TOP)) begin
        hold_d[c] = hold_q[c] + HOLD_ONE;
      end
    end
  end

  logic start_p_q, start_p_d;
  logic stop_p_q, stop_p_d;
  logic reset_p_q, reset_p_d;
  logic inc_min_p_q, inc_min_p_d;
  logic inc_sec_p_q, inc_sec_p_d;
  logic dir_q, dir_d;
  logic cmd_mask;

  always_comb begin
    cmd_mask    = stable_vec[RESET] | rise_vec[RESET];
    reset_p_d   = rise_vec[RESET];
    stop_p_d    = rise_vec[STOP] & ~cmd_mask;
    start_p_d   = rise_vec[START] & ~rise_vec[STOP] & ~cmd_mask;
    inc_min_p_d = (rise_vec[MIN] | rep[0]) & ~cmd_mask;
    inc_sec_p_d = (rise_vec[SEC] | rep[1]) & ~cmd_mask;
    dir_d       = stable_vec[DIR];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_p_q   <= 1'b0;
      stop_p_q    <= 1'b0;
      reset_p_q   <= 1'b0;
      inc_min_p_q <= 1'b0;
      inc_sec_p_q <= 1'b0;
      dir_q       <= 1'b0;
      for (int unsigned c = 0; c < 2; c++) hold_q[c] <= '0;
    end else begin
      start_p_q   <= start_p_d;
      stop_p_q    <= stop_p_d;
      reset_p_q   <= reset_p_d;
      inc_min_p_q <= inc_min_p_d;
      inc_sec_p_q <= inc_sec_p_d;
      dir_q       <= dir_d;
      for (int unsigned c = 0; c < 2; c++) hold_q[c] <= hold_d[c];
    end
  end

  assign start_p   = start_p_q;
  assign stop_p    = stop_p_q;
  assign reset_p   = reset_p_q;
  assign inc_min_p = inc_min_p_q;
  assign inc_sec_p = inc_sec_p_q;
  assign dir       = dir_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a cycle-level
// behavioural model of the debounce, priority and auto-repeat rules.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int HOLD = 10;
  localparam int REP = 3;
  localparam int I_START = 0, I_STOP = 1, I_RESET = 2, I_MIN = 3, I_SEC = 4, I_DIR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [5:0] raw_drv = '0;
  logic start_p, stop_p, reset_p, inc_min_p, inc_sec_p, dir;

  button_conditioner #(.DEBOUNCE_MS(DEB), .HOLD_MS(HOLD), .REPEAT_MS(REP)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1k   (tick),
    .btn_start (raw_drv[I_START]),
    .btn_stop  (raw_drv[I_STOP]),
    .btn_reset (raw_drv[I_RESET]),
    .btn_min   (raw_drv[I_MIN]),
    .btn_sec   (raw_drv[I_SEC]),
    .sw_dir    (raw_drv[I_DIR]),
    .start_p   (start_p),
    .stop_p    (stop_p),
    .reset_p   (reset_p),
    .inc_min_p (inc_min_p),
    .inc_sec_p (inc_sec_p),
    .dir       (dir)
  );

  initial forever #5 clk = ~clk;

  int tick_ph = 0;
  initial forever begin
    @(negedge clk);
    tick_ph = (tick_ph + 1) % 8;
    tick = (tick_ph == 0);
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: integer bookkeeping of sync delay, debounce runs and hold ticks.
  int m_s1[6], m_s2[6], m_stab[6], m_prev[6], m_run[6];
  int m_held[2], m_due[2];
  logic [5:0] exp_vec = '0;

  always @(posedge clk) begin
    int press[6];
    int mask;
    if (rst) begin
      for (int b = 0; b < 6; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_prev[b] = 0; m_run[b] = 0;
      end
      for (int c = 0; c < 2; c++) begin m_held[c] = 0; m_due[c] = 0; end
      exp_vec = '0;
    end else begin
      for (int b = 0; b < 6; b++) press[b] = (m_stab[b] == 1 && m_prev[b] == 0) ? 1 : 0;
      mask = m_stab[I_RESET];
      exp_vec[I_RESET] = press[I_RESET] != 0;
      exp_vec[I_STOP]  = press[I_STOP] != 0 && mask == 0;
      exp_vec[I_START] = press[I_START] != 0 && press[I_STOP] == 0 && mask == 0;
      for (int c = 0; c < 2; c++)
        exp_vec[I_MIN + c] = (press[I_MIN + c] != 0 || (m_due[c] != 0 && m_stab[I_MIN + c] != 0))
                             && mask == 0;
      exp_vec[I_DIR] = m_stab[I_DIR] != 0;
      // Repeats land on ticks HOLD, HOLD+REP, HOLD+2*REP, ... counted from the press.
      for (int c = 0; c < 2; c++) begin
        m_due[c] = 0;
        if (m_stab[I_MIN + c] == 0 || press[I_MIN + c] != 0) m_held[c] = 0;
        else if (tick) begin
          m_held[c]++;
          if (m_held[c] >= HOLD && (m_held[c] - HOLD) % REP == 0) m_due[c] = 1;
        end
      end
      for (int b = 0; b < 6; b++) begin
        m_prev[b] = m_stab[b];
        if (m_s2[b] != m_stab[b]) begin
          if (tick) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin m_stab[b] = m_s2[b]; m_run[b] = 0; end
          end
        end else m_run[b] = 0;
        m_s2[b] = m_s1[b];
        m_s1[b] = raw_drv[b] ? 1 : 0;
      end
    end
  end

  int tick_total = 0;
  int cnt_start = 0, cnt_stop = 0, cnt_reset = 0, cnt_min = 0, cnt_sec = 0;

  always @(posedge clk) begin
    if (tick) tick_total++;
    #1;
    check("outs", {26'd0, dir, inc_sec_p, inc_min_p, reset_p, stop_p, start_p}, {26'd0, exp_vec});
    cnt_start += int'(start_p);
    cnt_stop  += int'(stop_p);
    cnt_reset += int'(reset_p);
    cnt_min   += int'(inc_min_p);
    cnt_sec   += int'(inc_sec_p);
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_min_pulse(input string tag, input int budget);
    int base = cnt_min;
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (cnt_min != base) seen = 1;
    end
    if (!seen) check(tag, 0, 1);
  endtask

  int b_start, b_stop, b_reset, b_min, b_sec, b_tick, b_all;

  initial begin
    repeat (4) @(negedge clk);
    check("reset_outs", {26'd0, dir, inc_sec_p, inc_min_p, reset_p, stop_p, start_p}, 0);
    rst = 1'b0;
    wait_ticks(2);

    b_start = cnt_start;
    for (int i = 0; i < 5; i++) begin
      raw_drv[I_START] = 1'b1; wait_ticks(2);
      raw_drv[I_START] = 1'b0; wait_ticks(2);
    end
    wait_ticks(6);
    check("bounce_start", cnt_start - b_start, 0);

    b_start = cnt_start;
    raw_drv[I_START] = 1'b1; wait_ticks(30);
    check("press_start", cnt_start - b_start, 1);
    raw_drv[I_START] = 1'b0; wait_ticks(8);
    check("release_start", cnt_start - b_start, 1);

    b_min = cnt_min; b_sec = cnt_sec;
    raw_drv[I_MIN] = 1'b1;
    wait_min_pulse("min_press_timeout", 200);
    wait_ticks(17);
    raw_drv[I_MIN] = 1'b0;
    wait_ticks(8);
    check("repeat_min", cnt_min - b_min, 5);
    check("repeat_sec", cnt_sec - b_sec, 0);

    b_start = cnt_start; b_stop = cnt_stop;
    raw_drv[I_START] = 1'b1; raw_drv[I_STOP] = 1'b1;
    wait_ticks(6);
    check("prio_stop", cnt_stop - b_stop, 1);
    check("prio_start", cnt_start - b_start, 0);
    raw_drv[I_START] = 1'b0; raw_drv[I_STOP] = 1'b0;
    wait_ticks(6);

    b_reset = cnt_reset; b_sec = cnt_sec;
    raw_drv[I_RESET] = 1'b1; wait_ticks(6);
    raw_drv[I_SEC] = 1'b1;   wait_ticks(14);
    raw_drv[I_SEC] = 1'b0;   wait_ticks(6);
    raw_drv[I_RESET] = 1'b0; wait_ticks(6);
    check("mask_reset", cnt_reset - b_reset, 1);
    check("mask_sec", cnt_sec - b_sec, 0);

    raw_drv[I_MIN] = 1'b1;
    wait_min_pulse("min_hold_timeout", 200);
    wait_ticks(12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", {26'd0, dir, inc_sec_p, inc_min_p, reset_p, stop_p, start_p}, 0);
    b_tick = tick_total;
    wait_min_pulse("rearm_timeout", 200);
    check("rearm_ticks", tick_total - b_tick, DEB);
    b_tick = tick_total;
    wait_min_pulse("rerepeat_timeout", 200);
    check("rerepeat_ticks", tick_total - b_tick, HOLD);
    raw_drv[I_MIN] = 1'b0;
    wait_ticks(8);

    b_all = cnt_start + cnt_stop + cnt_reset + cnt_min + cnt_sec;
    raw_drv[I_DIR] = 1'b1;
    wait_ticks(DEB);
    check("dir_before", {31'd0, dir}, 0);
    @(posedge clk); #1;
    check("dir_after", {31'd0, dir}, 1);
    @(negedge clk);
    check("dir_no_cmd", cnt_start + cnt_stop + cnt_reset + cnt_min + cnt_sec - b_all, 0);
    raw_drv[I_DIR] = 1'b0;
    wait_ticks(6);

    for (int it = 0; it < 250; it++) begin
      int b;
      b = $urandom_range(0, 5);
      raw_drv[b] = ~raw_drv[b];
      repeat ($urandom_range(1, 60)) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    raw_drv = '0;
    wait_ticks(HOLD + 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
